// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: repeat-FSM state encoding
// and the lower limits on legal parameter values.
package btn_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE      = 2'd0,
    RPT_HOLD_WAIT = 2'd1,
    RPT_REPEAT    = 2'd2
  } rpt_state_e;

  localparam int unsigned MIN_N_BTN           = 1;
  localparam int unsigned MIN_SYNC_STAGES     = 2;
  localparam int unsigned MIN_DEBOUNCE_CYCLES = 1;
  localparam int unsigned MIN_REPEAT_DELAY    = 1;
  localparam int unsigned MIN_REPEAT_RATE     = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw inputs and repeat enable in, conditioned levels/pulses out.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 4
) ();
  logic [N_BTN-1:0] btn_in;
  logic             rep_en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic             any_press;

  modport master (
    output btn_in, rep_en,
    input  btn_level, btn_press, btn_release, btn_repeat, any_press
  );

  modport slave (
    input  btn_in, rep_en,
    output btn_level, btn_press, btn_release, btn_repeat, any_press
  );
endinterface

// File: rtl/btn_channel.sv
// One button channel: input synchronizer, debounce counter with registered
// press/release pulses, and an auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_RATE     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic rep_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic press_d_o
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_V = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RATE_V  = RPT_W'(REPEAT_RATE);
  localparam logic [RPT_W-1:0] ONE_V   = RPT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;
  logic [RPT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
  rpt_state_e             state_q, state_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (synced == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d   = synced;
      db_cnt_d  = '0;
      press_d   = synced;
      release_d = ~synced;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Repeat FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RPT_IDLE;
    else     state_q <= state_d;
  end

  // Repeat FSM: next state; release or disable pre-empts any due repeat
  always_comb begin
    state_d = state_q;
    if (release_d || !rep_en_i) begin
      state_d = RPT_IDLE;
    end else begin
      unique case (state_q)
        RPT_IDLE:      if (press_d) state_d = RPT_HOLD_WAIT;
        RPT_HOLD_WAIT: if (rpt_cnt_q == DELAY_V) state_d = RPT_REPEAT;
        RPT_REPEAT:    state_d = RPT_REPEAT;
        default:       state_d = RPT_IDLE;
      endcase
    end
  end

  // Repeat FSM: outputs and repeat counter
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    if (release_d || !rep_en_i) begin
      rpt_cnt_d = '0;
    end else begin
      unique case (state_q)
        RPT_IDLE: rpt_cnt_d = press_d ? ONE_V : '0;
        RPT_HOLD_WAIT: begin
          if (rpt_cnt_q == DELAY_V) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = ONE_V;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (rpt_cnt_q == RATE_V) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = ONE_V;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: rpt_cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
  assign press_d_o = press_d;

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent debounced button channels with auto-repeat and a
// registered any-press flag.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_RATE     = 3
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  if (N_BTN < MIN_N_BTN || SYNC_STAGES < MIN_SYNC_STAGES ||
      DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES || REPEAT_DELAY < MIN_REPEAT_DELAY ||
      REPEAT_RATE < MIN_REPEAT_RATE) begin : g_param_check
    $fatal(1, "button_conditioner: illegal parameter value");
  end

  logic [N_BTN-1:0] level, press, release_p, repeat_p, press_d;
  logic             any_press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (bus.btn_in[i]),
      .rep_en_i  (bus.rep_en),
      .level_o   (level[i]),
      .press_o   (press[i]),
      .release_o (release_p[i]),
      .repeat_o  (repeat_p[i]),
      .press_d_o (press_d[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_press_q <= 1'b0;
    else     any_press_q <= |press_d;
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = release_p;
  assign bus.btn_repeat  = repeat_p;
  assign bus.any_press   = any_press_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL provide parameter N_BTN, default 4: number of independent button channels.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: synchronizer flop depth, minimum 2.
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 4: consecutive stable synced cycles needed to accept a change, minimum 1.
REQ-004 SHALL provide parameter REPEAT_DELAY, default 10: cycles from the accepted press to the first repeat pulse, minimum 1.
REQ-005 SHALL provide parameter REPEAT_RATE, default 3: cycles between later repeat pulses, minimum 1.
REQ-006 Port clk, input, 1: clock; reset rst, asynchronous, active-high; clock clk.
REQ-007 Port rst, input, 1: asynchronous active-high reset.
REQ-008 Port btn_in, input, N_BTN: raw asynchronous button levels.
REQ-009 Port rep_en, input, 1: synchronous auto-repeat enable, shared by all channels.
REQ-010 Port btn_level, output, N_BTN: debounced level per channel.
REQ-011 Port btn_press, output, N_BTN: one-cycle pulse on an accepted 0->1 change.
REQ-012 Port btn_release, output, N_BTN: one-cycle pulse on an accepted 1->0 change.
REQ-013 Port btn_repeat, output, N_BTN: one-cycle auto-repeat pulse while held.
REQ-014 Port any_press, output, 1: registered OR of the btn_press conditions.

Function
REQ-015 Each channel SHALL pass btn_in[i] through a SYNC_STAGES-deep flop chain; the last stage is the synced value.
REQ-016 Each channel SHALL hold a debounce counter of width clog2(DEBOUNCE_CYCLES)+1.
- Clear the counter when synced equals btn_level.
- Otherwise, increment the counter each edge.
REQ-017 At an edge where synced differs from btn_level and the counter equals DEBOUNCE_CYCLES-1, the channel SHALL:
- load btn_level with synced,
- clear the counter,
- register btn_press or btn_release high for exactly that one cycle.
REQ-018 Latency: with btn_in changed and stable before edge 1, btn_level and the pulse SHALL change after edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-019 A synced excursion shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse and no btn_level change.
REQ-020 Each channel SHALL run a repeat FSM with states IDLE, HOLD_WAIT and REPEAT.
REQ-021 Repeat FSM transitions and outputs:
- IDLE -> HOLD_WAIT on an accepted press while rep_en=1, with the repeat counter loaded to 1.
- HOLD_WAIT: on counter==REPEAT_DELAY, pulse btn_repeat and go to REPEAT with counter=1.
- REPEAT: on counter==REPEAT_RATE, pulse btn_repeat and reload counter=1.
REQ-022 An accepted release, or rep_en=0, SHALL force IDLE at that edge, and no btn_repeat SHALL be issued in that cycle.
REQ-023 After rep_en rises during a hold, repeats SHALL resume only after a new accepted press.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-025 All outputs SHALL be registered; btn_press, btn_release and btn_repeat SHALL never be high for two consecutive cycles from the same event.

Reset
REQ-026 rst SHALL asynchronously clear all sync flops, debounce counters, repeat counters, btn_level and all pulse outputs, and set every FSM to IDLE.
REQ-027 Reset mid-operation SHALL emit no release pulse.
REQ-028 Out of reset, an input held high SHALL be handled as a fresh press, with the latency of REQ-018.

Structure
REQ-029 Shared package btn_pkg SHALL hold the repeat-FSM state enum and the parameter-legality limits.
REQ-030 Per-channel logic SHALL be a sub-module btn_channel (sync, debounce and repeat FSM), instantiated N_BTN times by generate.
REQ-031 Illegal parameters SHALL fail elaboration.

Verification (N_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-032 Clean press on ch0 before edge 1 -> btn_level[0]=1 and btn_press[0]=1 after edge 6, and btn_press[0]=0 after edge 7.
REQ-033 3-cycle high glitch on ch1 -> btn_level[1], btn_press[1] and btn_release[1] all stay 0.
REQ-034 ch2 held with rep_en=1, press pulse at cycle P -> btn_repeat[2] at P+10, P+13, P+16, P+19 only.
REQ-035 ch0 and ch3 pressed together -> btn_press=4'b1001 for one cycle and any_press=1 for that same single cycle.
REQ-036 Release ch2 while in REPEAT, on a cycle where a repeat is due -> btn_release[2]=1 with btn_repeat[2]=0, then the FSM is in IDLE.
REQ-037 rst asserted while ch0 is held -> all outputs 0 at once with no release pulse; after rst drops with btn_in[0] still high -> btn_press[0] after edge 6.
